// File: rtl/ax_channel_arbiter_pkg.sv
// Shared AXI definitions for the address-channel arbiter.
// Grant encodings and the arbiter state type.
package axi_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_ID_W   = 4;
  localparam int AXI_DATA_W = 64;
  localparam int AXI_LEN_W  = 8;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } arb_state_e;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

endpackage

// File: rtl/ax_channel_arbiter_rr_pick.sv
// Two-way round-robin picker.
// On a tie the master that did not win last time is chosen.
module ax_rr_pick
  import axi_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_prio,
  output logic [1:0] winner
);

  always_comb begin
    winner = GNT_NONE;
    unique case (req)
      2'b01:   winner = GNT_M0;
      2'b10:   winner = GNT_M1;
      2'b11:   winner = last_prio ? GNT_M0 : GNT_M1;
      default: winner = GNT_NONE;
    endcase
  end

endmodule

// File: rtl/ax_channel_arbiter.sv
// Two-master arbiter for one AXI address channel (AW or AR).
// Grant is held until the address (or completion) handshake.
module ax_channel_arbiter
  import axi_pkg::*;
#(
  parameter bit RESET_PRIO = 1'b0,
  parameter bit HOLD_DATA  = 1'b1
) (
  input  logic       ACLK,
  input  logic       ARESETn,
  input  logic       AxVALID_M0,
  input  logic       AxVALID_M1,
  input  logic       AxREADY_S,
  input  logic       done_valid,
  input  logic       done_ready,
  output logic [1:0] gnt,
  output logic       AxREADY_M0,
  output logic       AxREADY_M1,
  output logic       busy
);

  arb_state_e state;
  logic       last_prio;
  logic [1:0] pick;
  logic [1:0] valid;
  logic       addr_hs;
  logic       done_hs;
  logic       in_addr;

  assign valid   = {AxVALID_M1, AxVALID_M0};
  assign addr_hs = AxREADY_S & |(gnt & valid);
  assign done_hs = done_valid & done_ready;
  assign in_addr = (state == ADDR);

  ax_rr_pick u_pick (
    .req       (valid),
    .last_prio (last_prio),
    .winner    (pick)
  );

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state     <= IDLE;
      gnt       <= GNT_NONE;
      busy      <= 1'b0;
      last_prio <= RESET_PRIO;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick != GNT_NONE) begin
            state     <= ADDR;
            gnt       <= pick;
            busy      <= 1'b1;
            last_prio <= pick[1];
          end
        end
        ADDR: begin
          if (addr_hs) begin
            if (HOLD_DATA) begin
              state <= DATA;
            end else begin
              state <= IDLE;
              gnt   <= GNT_NONE;
              busy  <= 1'b0;
            end
          end
        end
        DATA: begin
          if (done_hs) begin
            state <= IDLE;
            gnt   <= GNT_NONE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= GNT_NONE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Ready reaches only the owner, and only while the address is pending
  assign AxREADY_M0 = AxREADY_S & gnt[0] & in_addr;
  assign AxREADY_M1 = AxREADY_S & gnt[1] & in_addr;

endmodule

// File: tb/tb_ax_channel_arbiter.sv
// Scoreboard bench for ax_channel_arbiter, both HOLD_DATA flavours.
// Expected outputs come from a transaction-owner reference model.
module tb_ax_channel_arbiter;

  logic       clk = 1'b0;
  logic       rstn;
  logic       v0, v1, rs, dv, dr;
  logic [1:0] gnt_a, gnt_b;
  logic       r0_a, r1_a, busy_a;
  logic       r0_b, r1_b, busy_b;

  always #5 clk = ~clk;

  ax_channel_arbiter #(.RESET_PRIO(1'b0), .HOLD_DATA(1'b1)) dut_hold (
    .ACLK       (clk),
    .ARESETn    (rstn),
    .AxVALID_M0 (v0),
    .AxVALID_M1 (v1),
    .AxREADY_S  (rs),
    .done_valid (dv),
    .done_ready (dr),
    .gnt        (gnt_a),
    .AxREADY_M0 (r0_a),
    .AxREADY_M1 (r1_a),
    .busy       (busy_a)
  );

  ax_channel_arbiter #(.RESET_PRIO(1'b0), .HOLD_DATA(1'b0)) dut_rel (
    .ACLK       (clk),
    .ARESETn    (rstn),
    .AxVALID_M0 (v0),
    .AxVALID_M1 (v1),
    .AxREADY_S  (rs),
    .done_valid (dv),
    .done_ready (dr),
    .gnt        (gnt_b),
    .AxREADY_M0 (r0_b),
    .AxREADY_M1 (r1_b),
    .busy       (busy_b)
  );

  // Per instance: owner master (-1 none), waiting-for-done flag, last winner
  int owner [2];
  int wait_done [2];
  int last [2];
  int holds [2];

  logic [9:0] expq [$];
  int checks = 0;
  int passed = 0;

  function automatic logic [4:0] predict(int k, logic s);
    logic [4:0] e;
    e[4:3] = (owner[k] < 0) ? 2'b00 : ((owner[k] == 0) ? 2'b01 : 2'b10);
    e[2]   = (owner[k] >= 0);
    e[1]   = s && owner[k] == 0 && wait_done[k] == 0;
    e[0]   = s && owner[k] == 1 && wait_done[k] == 0;
    return e;
  endfunction

  task automatic advance(int k);
    bit vv [2];
    vv[0] = v0;
    vv[1] = v1;
    if (!rstn) begin
      owner[k] = -1;
      wait_done[k] = 0;
      last[k] = 0;
    end else if (owner[k] < 0) begin
      if (v0 || v1) begin
        if (v0 && v1) owner[k] = 1 - last[k];
        else owner[k] = v0 ? 0 : 1;
        last[k] = owner[k];
        wait_done[k] = 0;
      end
    end else if (wait_done[k] == 0) begin
      if (vv[owner[k]] && rs) begin
        if (holds[k] != 0) wait_done[k] = 1;
        else owner[k] = -1;
      end
    end else if (dv && dr) begin
      owner[k] = -1;
      wait_done[k] = 0;
    end
  endtask

  task automatic step(logic a0, logic a1, logic s, logic d, logic e, logic r);
    @(posedge clk);
    #1;
    v0 = a0; v1 = a1; rs = s; dv = d; dr = e; rstn = r;
    expq.push_back({predict(0, s), predict(1, s)});
    advance(0);
    advance(1);
  endtask

  always @(negedge clk) begin
    if (expq.size() > 0) begin
      logic [9:0] e;
      logic [4:0] act_a, act_b;
      e = expq.pop_front();
      act_a = {gnt_a, busy_a, r0_a, r1_a};
      act_b = {gnt_b, busy_b, r0_b, r1_b};
      checks++;
      if (act_a === e[9:5]) passed++;
      else $display("FAIL hold_outputs t=%0t got gnt/busy/r0/r1=%b want %b",
                    $time, act_a, e[9:5]);
      checks++;
      if (act_b === e[4:0]) passed++;
      else $display("FAIL rel_outputs t=%0t got gnt/busy/r0/r1=%b want %b",
                    $time, act_b, e[4:0]);
    end
  end

  initial begin
    holds[0] = 1;
    holds[1] = 0;
    for (int k = 0; k < 2; k++) begin
      owner[k] = -1;
      wait_done[k] = 0;
      last[k] = 0;
    end
    rstn = 1'b0;
    v0 = 1'b1; v1 = 1'b1; rs = 1'b0; dv = 1'b0; dr = 1'b0;

    // Reset held with both masters requesting
    repeat (3) step(1, 1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);

    // Single request from M1, late address ready, then completion
    step(0, 1, 0, 0, 0, 1);
    step(0, 1, 0, 1, 1, 1);
    step(0, 1, 0, 0, 0, 1);
    step(0, 1, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 1, 1);
    step(0, 0, 0, 0, 0, 1);

    // Both always valid, four transactions
    for (int t = 0; t < 4; t++) begin
      step(1, 1, 0, 0, 0, 1);
      step(1, 1, 1, 0, 0, 1);
      step(1, 1, 0, 1, 1, 1);
      step(1, 1, 0, 0, 0, 1);
    end
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);

    // Hold in DATA: ready ignored, done needs both valid and ready
    step(1, 0, 1, 0, 0, 1);
    step(1, 0, 1, 0, 0, 1);
    repeat (5) step(1, 0, 1, 0, 0, 1);
    step(0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1, 1);
    step(0, 0, 0, 0, 0, 1);

    // Reset in the middle of a transaction, then tie after release
    step(0, 1, 0, 0, 0, 1);
    step(0, 1, 1, 0, 0, 1);
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 1);
    step(1, 1, 1, 0, 0, 1);
    step(0, 0, 0, 1, 1, 1);
    step(0, 0, 0, 0, 0, 1);

    // Randomized traffic with occasional reset
    for (int t = 0; t < 3000; t++) begin
      step(logic'($urandom_range(0, 3) != 0),
           logic'($urandom_range(0, 3) != 0),
           logic'($urandom_range(0, 1)),
           logic'($urandom_range(0, 2) == 0),
           logic'($urandom_range(0, 1)),
           logic'($urandom_range(0, 99) != 0));
    end

    @(negedge clk);
    #1;
    checks++;
    if (expq.size() == 0) passed++;
    else $display("FAIL drain got %0d pending want 0", expq.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
